// File: rtl/xor_cmp_sched.sv
// xor_cmp_sched: round-robin scheduler for a shared byte-XOR comparator.
// Any nonzero XOR is latched into DIFF/SRC and raised as a held interrupt.
// The processor acknowledges the interrupt and reads results through a
// registered port bus.
// Optional build macro: XOR_CMP_SCHED_MASK_EN adds a per-requester MASK register at 0x05.
//
// Handshake: a requester holds req[i] high until gnt[i] pulses for one cycle.
// The pair is captured on that same edge, and the requester drops req the
// following cycle. A req that is still high once the block is back in IDLE
// is treated as a new request.
module xor_cmp_sched #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] data_a,
    input  logic [8*NUM_REQ-1:0] data_b,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    input  logic [7:0]           port_id,
    input  logic                 read_strobe,
    input  logic                 write_strobe,
    input  logic [7:0]           out_port,
    output logic [7:0]           in_port
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COMPARE  = 2'd1;
    localparam logic [1:0] ST_IRQ_PEND = 2'd2;

    logic [1:0]         state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      cap_src;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      cand;
    logic               found;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] win_onehot;
    logic [7:0]         sel_a, sel_b;
    logic [7:0]         cap_a, cap_b;
    logic [7:0]         diff;
    logic [7:0]         diff_reg, src_reg, mcnt, pcnt;
    logic [7:0]         rd_data;
    logic               inc_mcnt, inc_pcnt, clr_mcnt, clr_pcnt;
    logic               unused_bus;

`ifdef XOR_CMP_SCHED_MASK_EN
    logic [7:0] mask_reg;

    // MASK register: a set bit removes that requester from arbitration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_reg <= 8'h00;
        end else if (write_strobe && port_id == 8'h05) begin
            mask_reg <= out_port;
        end
    end

    assign eligible   = req & ~mask_reg[NUM_REQ-1:0];
    assign unused_bus = read_strobe;
`else
    assign eligible   = req;
    assign unused_bus = ^{read_strobe, out_port};
`endif

    assign diff     = cap_a ^ cap_b;
    assign inc_mcnt = (state == ST_COMPARE) && (diff != 8'h00);
    assign inc_pcnt = (state == ST_COMPARE) && (diff == 8'h00);
    assign clr_mcnt = write_strobe && (port_id == 8'h02);
    assign clr_pcnt = write_strobe && (port_id == 8'h03);

    // Round-robin search: first eligible requester after rr_ptr, with wrap
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Select the winner's operands and build its one-hot grant
    always_comb begin
        sel_a      = 8'h00;
        sel_b      = 8'h00;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IW'(i)) begin
                sel_a         = data_a[8*i +: 8];
                sel_b         = data_b[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Scheduler FSM: grant and capture, compare, then hold the interrupt until acked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= IW'(NUM_REQ - 1);
            gnt       <= '0;
            interrupt <= 1'b0;
            cap_a     <= 8'h00;
            cap_b     <= 8'h00;
            cap_src   <= '0;
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        cap_a   <= sel_a;
                        cap_b   <= sel_b;
                        cap_src <= winner;
                        rr_ptr  <= winner;
                        gnt     <= win_onehot;
                        state   <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (diff != 8'h00) begin
                        interrupt <= 1'b1;
                        state     <= ST_IRQ_PEND;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_IRQ_PEND: begin
                    if (interrupt_ack) begin
                        interrupt <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result registers; a clear write wins over a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            diff_reg <= 8'h00;
            src_reg  <= 8'h00;
            mcnt     <= 8'h00;
            pcnt     <= 8'h00;
        end else begin
            if (inc_mcnt) begin
                diff_reg <= diff;
                src_reg  <= {{(8-IW){1'b0}}, cap_src};
            end
            if (clr_mcnt) begin
                mcnt <= 8'h00;
            end else if (inc_mcnt && mcnt != 8'hFF) begin
                mcnt <= mcnt + 8'h01;
            end
            if (clr_pcnt) begin
                pcnt <= 8'h00;
            end else if (inc_pcnt && pcnt != 8'hFF) begin
                pcnt <= pcnt + 8'h01;
            end
        end
    end

    // Read mux over current (pre-update) register values
    always_comb begin
        rd_data = 8'h00;
        case (port_id)
            8'h00: rd_data = diff_reg;
            8'h01: rd_data = src_reg;
            8'h02: rd_data = mcnt;
            8'h03: rd_data = pcnt;
            8'h04: rd_data = {5'b00000, state, interrupt};
`ifdef XOR_CMP_SCHED_MASK_EN
            8'h05: rd_data = mask_reg;
`endif
            default: rd_data = 8'h00;
        endcase
    end

    // Registered read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_port <= 8'h00;
        end else begin
            in_port <= rd_data;
        end
    end

endmodule
